melody_sequencer: RTL and testbench

MELODY_SEQUENCER -- requirements
Module: melody_sequencer

---
 rtl/melody_sequencer_if.sv | 46 ++++
 rtl/melody_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_melody_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/melody_sequencer_if.sv
// Score-load and playback handshake bundle for the melody sequencer.
// The master side is the controller; the slave side is the sequencer.
interface melody_sequencer_if;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [4:0]  wr_data;
  logic [3:0]  song_len;
  logic        start;
  logic        stop;
  logic        loop_en;
  logic [16:0] tone_period;
  logic        tone_en;
  logic        busy;
  logic        done;
  logic [3:0]  note_idx;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    output song_len,
    output start,
    output stop,
    output loop_en,
    input  tone_period,
    input  tone_en,
    input  busy,
    input  done,
    input  note_idx
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  song_len,
    input  start,
    input  stop,
    input  loop_en,
    output tone_period,
    output tone_en,
    output busy,
    output done,
    output note_idx
  );
endinterface

// File: rtl/melody_sequencer.sv
// Plays a 16-entry score of notes and rests, driving a tone generator
// with a period count, with gap, loop and abort handling.
module melody_sequencer #(
  parameter int BEAT_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 2_500_000
) (
  input logic              clk,
  input logic              rst,
  melody_sequencer_if.slave bus
);

  localparam int CNT_MAX =
    (4 * BEAT_CYCLES > GAP_CYCLES) ?
    4 * BEAT_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] L0 =
    CW'(BEAT_CYCLES - 1);
  localparam logic [CW-1:0] L1 =
    CW'(2 * BEAT_CYCLES - 1);
  localparam logic [CW-1:0] L2 =
    CW'(3 * BEAT_CYCLES - 1);
  localparam logic [CW-1:0] L3 =
    CW'(4 * BEAT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST =
    CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE =
    CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PLAY,
    GAP,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [3:0]    len_q, len_d;
  logic [2:0]    code_q, code_d;
  logic [1:0]    dur_q, dur_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [16:0]   period_q, period_d;
  logic          tone_en_q, tone_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [4:0]    mem_q [16];
  logic [4:0]    entry;
  logic [CW-1:0] play_last;

  function automatic logic [16:0] note_period(
    input logic [2:0] c
  );
    logic [16:0] p;
    unique case (c)
      3'd1:    p = 17'd190837;
      3'd2:    p = 17'd170067;
      3'd3:    p = 17'd151513;
      3'd4:    p = 17'd143265;
      3'd5:    p = 17'd127549;
      3'd6:    p = 17'd113635;
      3'd7:    p = 17'd101213;
      default: p = 17'd0;
    endcase
    return p;
  endfunction

  // Score memory has no reset so it survives a reset pulse.
  always_ff @(posedge clk) begin
    if (bus.wr_en && !busy_q) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign entry = mem_q[idx_q];

  always_comb begin
    play_last = L0;
    unique case (dur_q)
      2'd0: play_last = L0;
      2'd1: play_last = L1;
      2'd2: play_last = L2;
      2'd3: play_last = L3;
      default: play_last = L0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    code_d   = code_q;
    dur_d    = dur_q;
    cnt_d    = cnt_q;
    period_d = period_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          len_d   = bus.song_len;
          idx_d   = 4'd0;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        code_d   = entry[4:2];
        dur_d    = entry[1:0];
        period_d = note_period(entry[4:2]);
        cnt_d    = '0;
        state_d  = PLAY;
      end
      PLAY: begin
        if (cnt_q == play_last) begin
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (idx_q < len_q) begin
            idx_d   = idx_q + 4'd1;
            state_d = LOAD;
          end else if (bus.loop_en) begin
            idx_d   = 4'd0;
            state_d = LOAD;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides every transition above.
    if (bus.stop && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
    end

    tone_en_d = (state_d == PLAY) &&
                (code_d != 3'd0);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= 4'd0;
      len_q     <= 4'd0;
      code_q    <= 3'd0;
      dur_q     <= 2'd0;
      cnt_q     <= '0;
      period_q  <= 17'd0;
      tone_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      code_q    <= code_d;
      dur_q     <= dur_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      tone_en_q <= tone_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.tone_period = period_q;
  assign bus.tone_en     = tone_en_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.note_idx    = idx_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed cycle-exact bench for melody_sequencer with
// BEAT_CYCLES=4 and GAP_CYCLES=2.
module tb_melody_sequencer;

  localparam int BEAT = 4;
  localparam int GAPC = 2;

  logic clk;
  logic rst;
  int   n_run;
  int   n_fail;

  melody_sequencer_if bus ();

  melody_sequencer #(
    .BEAT_CYCLES(BEAT),
    .GAP_CYCLES (GAPC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit hit, got running, need finished");
    $fatal(1, "watchdog");
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(
    input logic [3:0] a,
    input logic [2:0] code,
    input logic [1:0] dur
  );
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = {code, dur};
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic kick(input logic [3:0] len);
    bus.song_len = len;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
  endtask

  // Checks n PLAY cycles then the GAP; ends on the cycle after GAP.
  task automatic play_note(
    input string       tag,
    input logic [16:0] per,
    input logic        en,
    input int          n
  );
    for (int i = 0; i < n; i++) begin
      check({tag, " en"}, 32'(bus.tone_en), 32'(en));
      check({tag, " per"}, 32'(bus.tone_period), 32'(per));
      check({tag, " busy"}, 32'(bus.busy), 32'd1);
      check({tag, " done"}, 32'(bus.done), 32'd0);
      tick();
    end
    for (int g = 0; g < GAPC; g++) begin
      check({tag, " gap en"}, 32'(bus.tone_en), 32'd0);
      check({tag, " gap per"}, 32'(bus.tone_period), 32'(per));
      check({tag, " gap busy"}, 32'(bus.busy), 32'd1);
      tick();
    end
  endtask

  task automatic load_cyc(
    input string      tag,
    input logic [3:0] idx
  );
    check({tag, " load busy"}, 32'(bus.busy), 32'd1);
    check({tag, " load en"}, 32'(bus.tone_en), 32'd0);
    check({tag, " load idx"}, 32'(bus.note_idx), 32'(idx));
    check({tag, " load done"}, 32'(bus.done), 32'd0);
    tick();
  endtask

  task automatic done_cyc(input string tag);
    check({tag, " done hi"}, 32'(bus.done), 32'd1);
    check({tag, " done busy"}, 32'(bus.busy), 32'd1);
    check({tag, " done en"}, 32'(bus.tone_en), 32'd0);
    tick();
    check({tag, " post done"}, 32'(bus.done), 32'd0);
    check({tag, " post busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    n_run        = 0;
    n_fail       = 0;
    rst          = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = 4'd0;
    bus.wr_data  = 5'd0;
    bus.song_len = 4'd0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.loop_en  = 1'b0;

    #2;
    check("rst period", 32'(bus.tone_period), 32'd0);
    check("rst en", 32'(bus.tone_en), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst idx", 32'(bus.note_idx), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Two-note song
    wr(4'd0, 3'd1, 2'd0);
    wr(4'd1, 3'd3, 2'd1);
    kick(4'd1);
    load_cyc("s1 n0", 4'd0);
    play_note("s1 n0", 17'd190837, 1'b1, 4);
    load_cyc("s1 n1", 4'd1);
    play_note("s1 n1", 17'd151513, 1'b1, 8);
    done_cyc("s1");
    tick();

    // Rest of four beats
    wr(4'd0, 3'd0, 2'd3);
    kick(4'd0);
    load_cyc("rest", 4'd0);
    play_note("rest", 17'd0, 1'b0, 16);
    done_cyc("rest");
    tick();

    // Looping, released during the third pass
    wr(4'd0, 3'd5, 2'd0);
    bus.loop_en = 1'b1;
    kick(4'd0);
    load_cyc("loop p1", 4'd0);
    play_note("loop p1", 17'd127549, 1'b1, 4);
    load_cyc("loop p2", 4'd0);
    play_note("loop p2", 17'd127549, 1'b1, 4);
    bus.loop_en = 1'b0;
    load_cyc("loop p3", 4'd0);
    play_note("loop p3", 17'd127549, 1'b1, 4);
    done_cyc("loop");
    tick();

    // Abort during note 1
    wr(4'd0, 3'd1, 2'd0);
    kick(4'd1);
    load_cyc("stop n0", 4'd0);
    play_note("stop n0", 17'd190837, 1'b1, 4);
    load_cyc("stop n1", 4'd1);
    check("stop pre en", 32'(bus.tone_en), 32'd1);
    tick();
    tick();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("stop busy", 32'(bus.busy), 32'd0);
    check("stop en", 32'(bus.tone_en), 32'd0);
    check("stop done", 32'(bus.done), 32'd0);
    check("stop idx", 32'(bus.note_idx), 32'd1);
    tick();
    check("stop no done", 32'(bus.done), 32'd0);
    check("stop idle", 32'(bus.busy), 32'd0);

    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("st+sp busy", 32'(bus.busy), 32'd0);
    tick();
    check("st+sp busy2", 32'(bus.busy), 32'd0);

    // Write while busy is dropped
    kick(4'd0);
    check("wb busy", 32'(bus.busy), 32'd1);
    wr(4'd0, 3'd7, 2'd3);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("wb idle", 32'(bus.busy), 32'd0);
    kick(4'd0);
    load_cyc("wb", 4'd0);
    play_note("wb", 17'd190837, 1'b1, 4);
    done_cyc("wb");
    tick();

    // Async reset mid-note, score retained
    kick(4'd1);
    tick();
    check("mid en", 32'(bus.tone_en), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("ar en", 32'(bus.tone_en), 32'd0);
    check("ar busy", 32'(bus.busy), 32'd0);
    check("ar period", 32'(bus.tone_period), 32'd0);
    check("ar idx", 32'(bus.note_idx), 32'd0);
    check("ar done", 32'(bus.done), 32'd0);
    #2;
    rst = 1'b1;
    tick();
    check("ar stay idle", 32'(bus.busy), 32'd0);
    tick();
    check("ar stay idle2", 32'(bus.busy), 32'd0);
    kick(4'd1);
    load_cyc("ret n0", 4'd0);
    play_note("ret n0", 17'd190837, 1'b1, 4);
    load_cyc("ret n1", 4'd1);
    play_note("ret n1", 17'd151513, 1'b1, 8);
    done_cyc("ret");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
